truth_table_scanner: RTL

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner_pkg.sv | 20 ++
 rtl/truth_table_scanner_settle.sv | 29 ++
 rtl/truth_table_scanner.sv | 106 ++++++++++
 3 files changed

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and defaults for the truth-table scanner and its settle timer.
package truth_table_scanner_pkg;

  localparam int N_INPUTS_DEFAULT      = 4;
  localparam int SETTLE_CYCLES_DEFAULT = 2;
  localparam int TT_WIDTH              = 2 ** N_INPUTS_DEFAULT;
  localparam int SETTLE_CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int tt_width(input int n_inputs);
    return 2 ** n_inputs;
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle.sv
// Settle countdown: load arms it, count runs it, expire flags the last settle cycle.
module tt_settle_timer
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire
);

  logic [SETTLE_CNT_W-1:0] cnt_reg;

  // Loading SETTLE_CYCLES-1 makes expire land on the final settle cycle itself.
  assign expire = count && (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= SETTLE_CNT_W'(SETTLE_CYCLES - 1);
    end else if (count && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks every input vector of an external combinational function, captures its
// truth table and compares it against a golden table captured at start.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_INPUTS      = N_INPUTS_DEFAULT,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [2**N_INPUTS-1:0]     expected,
  input  logic                       func_out,
  output logic [N_INPUTS-1:0]        vec_out,
  output logic                       busy,
  output logic                       done,
  output logic [2**N_INPUTS-1:0]     table_out,
  output logic                       match,
  output logic [N_INPUTS:0]          mismatch_cnt,
  output logic [N_INPUTS-1:0]        mismatch_idx
);

  localparam int TW = tt_width(N_INPUTS);
  localparam logic [N_INPUTS-1:0] VEC_LAST = {N_INPUTS{1'b1}};

  state_t              state_reg;
  logic [N_INPUTS-1:0] vec_reg;
  logic [TW-1:0]       expected_reg;

  logic              timer_load;
  logic              timer_expire;
  logic              bit_diff;
  logic [N_INPUTS:0] cnt_next;

  // Re-arm the timer on acceptance and whenever a new vector is about to be applied.
  assign timer_load = ((state_reg == IDLE) && start) ||
                      ((state_reg == SAMPLE) && (vec_reg != VEC_LAST));
  assign bit_diff   = func_out ^ expected_reg[vec_reg];
  assign cnt_next   = mismatch_cnt + (N_INPUTS + 1)'(bit_diff);
  assign vec_out    = vec_reg;

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .count (state_reg == SETTLE),
    .expire(timer_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      vec_reg      <= '0;
      expected_reg <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      table_out    <= '0;
      match        <= 1'b0;
      mismatch_cnt <= '0;
      mismatch_idx <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            expected_reg <= expected;
            table_out    <= '0;
            mismatch_cnt <= '0;
            mismatch_idx <= '0;
            match        <= 1'b0;
            vec_reg      <= '0;
            busy         <= 1'b1;
            state_reg    <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_expire) state_reg <= SAMPLE;
        end
        SAMPLE: begin
          table_out[vec_reg] <= func_out;
          if (bit_diff) begin
            mismatch_cnt <= cnt_next;
            if (mismatch_cnt == '0) mismatch_idx <= vec_reg;
          end
          // match is settled together with done so it is valid on the pulse.
          if (vec_reg == VEC_LAST) begin
            done      <= 1'b1;
            match     <= (cnt_next == '0);
            state_reg <= DONE;
          end else begin
            vec_reg   <= vec_reg + 1'b1;
            state_reg <= SETTLE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
